// File: rtl/capture_sequencer.sv
// rtl/capture_sequencer.sv - trigger/capture sequencer with host register bus
// Optional auto-trigger timeout is built only when CAPTURE_AUTO_TRIG_EN is defined.
module capture_sequencer #(
    parameter int                    DATA_WIDTH = 16,
    parameter logic [DATA_WIDTH-1:0] BASE_ADDR  = 16'h4010,
    parameter int                    CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  addr_en,
    input  logic                  rd_en,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  adc_clk,
    input  logic                  sync_signal_in,
    input  logic                  stable,
    input  logic                  buf_done,
    output logic                  trig_pulse,
    output logic                  sample_stb,
    output logic                  capturing
);

    localparam logic [DATA_WIDTH-1:0] ADDR_CTRL    = BASE_ADDR;
    localparam logic [DATA_WIDTH-1:0] ADDR_HOLDOFF = BASE_ADDR + DATA_WIDTH'(1);
    localparam logic [DATA_WIDTH-1:0] ADDR_TIMEOUT = BASE_ADDR + DATA_WIDTH'(2);
    localparam logic [DATA_WIDTH-1:0] ADDR_DECIM   = BASE_ADDR + DATA_WIDTH'(3);
    localparam logic [DATA_WIDTH-1:0] ADDR_STATUS  = BASE_ADDR + DATA_WIDTH'(4);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_HOLDOFF = 3'd1,
        S_ARMED   = 3'd2,
        S_CAPTURE = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic [3:0]            ctrl_q, ctrl_d;
    logic                  force_q, force_d;
    logic [CNT_WIDTH-1:0]  holdoff_q, holdoff_d;
    logic [CNT_WIDTH-1:0]  decim_q, decim_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  done_q, done_d;
    logic [7:0]            count_q, count_d;
    logic                  sync_prev_q, adc_prev_q;
    logic                  trig_q, trig_d;
    logic                  stb_q, stb_d;
    logic                  capturing_q, capturing_d;

    logic                  bus_wr, bus_rd, wr_ctrl, rd_status;
    logic                  run, single, adc_rise, edge_hit, trig_hit;
    logic                  set_done, clr_run, auto_hit;
    logic [CNT_WIDTH-1:0]  timeout_load;
    logic [DATA_WIDTH-1:0] rd_val;

    assign bus_wr    = en & rd_en;
    assign bus_rd    = en & wr_en;
    assign wr_ctrl   = bus_wr && (addr_q == ADDR_CTRL);
    assign rd_status = bus_rd && (addr_q == ADDR_STATUS);

    assign run      = ctrl_q[0];
    assign single   = (ctrl_q[3:2] == 2'b00);
    assign adc_rise = adc_clk & ~adc_prev_q;
    assign edge_hit = ctrl_q[1] ? (~sync_signal_in & sync_prev_q)
                                : (sync_signal_in & ~sync_prev_q);

`ifdef CAPTURE_AUTO_TRIG_EN
    logic [CNT_WIDTH-1:0] timeout_q, timeout_d;

    // cnt_q holds the remaining timeout in ARMED; a zero load never fires
    assign auto_hit     = (ctrl_q[3:2] == 2'b10) && adc_rise && (cnt_q == CNT_WIDTH'(1));
    assign timeout_load = timeout_q;

    always_comb begin
        timeout_d = timeout_q;
        if (bus_wr && (addr_q == ADDR_TIMEOUT)) begin
            timeout_d = rd_data[CNT_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timeout_q <= '0;
        end else begin
            timeout_q <= timeout_d;
        end
    end
`else
    assign auto_hit     = 1'b0;
    assign timeout_load = '0;
`endif

    assign trig_hit = (edge_hit & stable) | force_q | auto_hit;

    always_comb begin
        rd_val = '1;
        case (addr_q)
            ADDR_CTRL:    rd_val = DATA_WIDTH'(ctrl_q);
            ADDR_HOLDOFF: rd_val = DATA_WIDTH'(holdoff_q);
`ifdef CAPTURE_AUTO_TRIG_EN
            ADDR_TIMEOUT: rd_val = DATA_WIDTH'(timeout_q);
`else
            ADDR_TIMEOUT: rd_val = '0;
`endif
            ADDR_DECIM:   rd_val = DATA_WIDTH'(decim_q);
            ADDR_STATUS:  rd_val = DATA_WIDTH'({count_q, 4'b0000, done_q, state_q});
            default:      rd_val = '1;
        endcase
    end

    // One shared counter: holdoff in HOLDOFF, timeout in ARMED, decimation in CAPTURE
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        trig_d   = 1'b0;
        stb_d    = 1'b0;
        set_done = 1'b0;
        clr_run  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (run) begin
                    state_d = S_HOLDOFF;
                    cnt_d   = holdoff_q;
                end
            end
            S_HOLDOFF: begin
                if (!run) begin
                    state_d = S_IDLE;
                end else if (cnt_q == '0) begin
                    state_d = S_ARMED;
                    cnt_d   = timeout_load;
                end else if (adc_rise) begin
                    cnt_d = cnt_q - CNT_WIDTH'(1);
                end
            end
            S_ARMED: begin
                if (!run) begin
                    state_d = S_IDLE;
                end else if (trig_hit) begin
                    state_d = S_CAPTURE;
                    trig_d  = 1'b1;
                    cnt_d   = '0;
                end else if (adc_rise && (cnt_q != '0)) begin
                    cnt_d = cnt_q - CNT_WIDTH'(1);
                end
            end
            S_CAPTURE: begin
                if (!stable || !run) begin
                    state_d = S_IDLE;
                end else if (buf_done) begin
                    state_d  = S_DONE;
                    set_done = 1'b1;
                end else if (adc_rise) begin
                    if (cnt_q == '0) begin
                        stb_d = 1'b1;
                        cnt_d = decim_q;
                    end else begin
                        cnt_d = cnt_q - CNT_WIDTH'(1);
                    end
                end
            end
            S_DONE: begin
                if (!run) begin
                    state_d = S_IDLE;
                end else if (single) begin
                    state_d = S_IDLE;
                    clr_run = 1'b1;
                end else begin
                    state_d = S_HOLDOFF;
                    cnt_d   = holdoff_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
        capturing_d = (state_d == S_CAPTURE);
    end

    always_comb begin
        addr_d    = (en && addr_en) ? rd_data : addr_q;
        wr_data_d = bus_rd ? rd_val : wr_data_q;
        ctrl_d    = ctrl_q;
        if (clr_run) begin
            ctrl_d[0] = 1'b0;
        end
        if (wr_ctrl) begin
            ctrl_d = rd_data[3:0];
        end
        force_d   = wr_ctrl & rd_data[4];
        holdoff_d = (bus_wr && (addr_q == ADDR_HOLDOFF)) ? rd_data[CNT_WIDTH-1:0] : holdoff_q;
        decim_d   = (bus_wr && (addr_q == ADDR_DECIM)) ? rd_data[CNT_WIDTH-1:0] : decim_q;
        // A done being set wins over a STATUS read clearing it in the same cycle
        done_d    = (done_q & ~rd_status) | set_done;
        count_d   = count_q + 8'(set_done);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            wr_data_q   <= '1;
            ctrl_q      <= '0;
            force_q     <= 1'b0;
            holdoff_q   <= '0;
            decim_q     <= '0;
            cnt_q       <= '0;
            done_q      <= 1'b0;
            count_q     <= '0;
            sync_prev_q <= 1'b0;
            adc_prev_q  <= 1'b0;
            trig_q      <= 1'b0;
            stb_q       <= 1'b0;
            capturing_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wr_data_q   <= wr_data_d;
            ctrl_q      <= ctrl_d;
            force_q     <= force_d;
            holdoff_q   <= holdoff_d;
            decim_q     <= decim_d;
            cnt_q       <= cnt_d;
            done_q      <= done_d;
            count_q     <= count_d;
            sync_prev_q <= sync_signal_in;
            adc_prev_q  <= adc_clk;
            trig_q      <= trig_d;
            stb_q       <= stb_d;
            capturing_q <= capturing_d;
        end
    end

    assign wr_data    = wr_data_q;
    assign trig_pulse = trig_q;
    assign sample_stb = stb_q;
    assign capturing  = capturing_q;

endmodule

// File: tb/tb_capture_sequencer.sv
// tb/tb_capture_sequencer.sv - randomized self-checking bench for capture_sequencer
module tb_capture_sequencer;

    localparam logic [15:0] A_CTRL = 16'h4010;
    localparam logic [15:0] A_HOLD = 16'h4011;
    localparam logic [15:0] A_TO   = 16'h4012;
    localparam logic [15:0] A_DEC  = 16'h4013;
    localparam logic [15:0] A_STAT = 16'h4014;
    localparam int S_IDLE = 0, S_HOLD = 1, S_ARMED = 2, S_CAP = 3, S_DONE = 4;
`ifdef CAPTURE_AUTO_TRIG_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        en = 1'b0, addr_en = 1'b0, rd_en = 1'b0, wr_en = 1'b0;
    logic [15:0] rd_data = 16'h0000;
    logic [15:0] wr_data;
    logic        adc_clk = 1'b0, sync_in = 1'b0, stable = 1'b1, buf_done = 1'b0;
    logic        trig_pulse, sample_stb, capturing;

    int vectors = 0, errors = 0, n_trig = 0, n_stb = 0;

    int          m_state, m_hcnt, m_hsnap, m_tcnt, m_tsnap, m_k;
    logic [3:0]  m_ctrl;
    logic        m_force, m_done, m_sync_prev, m_adc_prev;
    logic [15:0] m_hold, m_to, m_dec, m_addr, m_rdata;
    logic [7:0]  m_count;
    logic        e_trig, e_stb, e_cap;

    always #5 clk = ~clk;

    capture_sequencer #(.DATA_WIDTH(16), .BASE_ADDR(16'h4010), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .addr_en(addr_en), .rd_en(rd_en), .wr_en(wr_en),
        .rd_data(rd_data), .wr_data(wr_data), .adc_clk(adc_clk), .sync_signal_in(sync_in),
        .stable(stable), .buf_done(buf_done), .trig_pulse(trig_pulse),
        .sample_stb(sample_stb), .capturing(capturing)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = S_IDLE; m_hcnt = 0; m_hsnap = 0; m_tcnt = 0; m_tsnap = 0; m_k = 0;
        m_ctrl = 4'h0; m_force = 1'b0; m_done = 1'b0; m_sync_prev = 1'b0; m_adc_prev = 1'b0;
        m_hold = 16'h0; m_to = 16'h0; m_dec = 16'h0; m_addr = 16'h0; m_rdata = 16'hFFFF;
        m_count = 8'h0; e_trig = 1'b0; e_stb = 1'b0; e_cap = 1'b0;
    endtask

    function automatic logic [15:0] model_read(input logic [15:0] a);
        case (a)
            A_CTRL:  return {12'h000, m_ctrl};
            A_HOLD:  return m_hold;
            A_TO:    return m_to;
            A_DEC:   return m_dec;
            A_STAT:  return {m_count, 4'h0, m_done, 3'(m_state)};
            default: return 16'hFFFF;
        endcase
    endfunction

    // Predicts the outputs visible after the coming clock edge from the current inputs
    task automatic model_step();
        logic rise, sedge, run, fire, set_done, clr_run, bus_wr, bus_rd, auto_m;
        int ns;
        bus_wr = en && rd_en;
        bus_rd = en && wr_en;
        rise   = adc_clk && !m_adc_prev;
        sedge  = m_ctrl[1] ? (!sync_in && m_sync_prev) : (sync_in && !m_sync_prev);
        run    = m_ctrl[0];
        auto_m = AUTO && (m_ctrl[3:2] == 2'b10);
        set_done = 1'b0; clr_run = 1'b0; e_trig = 1'b0; e_stb = 1'b0; ns = m_state;
        if (bus_rd) m_rdata = model_read(m_addr);
        case (m_state)
            S_IDLE: if (run) begin ns = S_HOLD; m_hcnt = 0; m_hsnap = int'(m_hold); end
            S_HOLD: begin
                if (!run) ns = S_IDLE;
                else if (m_hcnt >= m_hsnap) begin ns = S_ARMED; m_tcnt = 0; m_tsnap = int'(m_to); end
                else if (rise) m_hcnt++;
            end
            S_ARMED: begin
                fire = (sedge && stable) || m_force ||
                       (auto_m && rise && m_tsnap != 0 && m_tcnt + 1 == m_tsnap);
                if (!run) ns = S_IDLE;
                else if (fire) begin e_trig = 1'b1; ns = S_CAP; m_k = 0; end
                else if (rise) m_tcnt++;
            end
            S_CAP: begin
                if (!stable || !run) ns = S_IDLE;
                else if (buf_done) begin ns = S_DONE; set_done = 1'b1; end
                else if (rise) begin
                    m_k++;
                    e_stb = (((m_k - 1) % (int'(m_dec) + 1)) == 0);
                end
            end
            S_DONE: begin
                if (!run) ns = S_IDLE;
                else if (m_ctrl[3:2] == 2'b00) begin clr_run = 1'b1; ns = S_IDLE; end
                else begin ns = S_HOLD; m_hcnt = 0; m_hsnap = int'(m_hold); end
            end
            default: ns = S_IDLE;
        endcase
        e_cap  = (ns == S_CAP);
        m_done = (m_done && !(bus_rd && m_addr == A_STAT)) || set_done;
        if (set_done) m_count++;
        if (clr_run) m_ctrl[0] = 1'b0;
        m_force = 1'b0;
        if (bus_wr) begin
            case (m_addr)
                A_CTRL: begin m_ctrl = rd_data[3:0]; m_force = rd_data[4]; end
                A_HOLD: m_hold = rd_data;
                A_TO:   if (AUTO) m_to = rd_data;
                A_DEC:  m_dec = rd_data;
                default: ;
            endcase
        end
        if (en && addr_en) m_addr = rd_data;
        m_sync_prev = sync_in;
        m_adc_prev  = adc_clk;
        m_state     = ns;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        vectors++;
        check("trig_pulse", 32'(trig_pulse), 32'(e_trig));
        check("sample_stb", 32'(sample_stb), 32'(e_stb));
        check("capturing", 32'(capturing), 32'(e_cap));
        check("wr_data", 32'(wr_data), 32'(m_rdata));
        n_trig += int'(trig_pulse);
        n_stb  += int'(sample_stb);
    endtask

    task automatic bus_addr(input logic [15:0] a);
        en = 1'b1; addr_en = 1'b1; rd_data = a;
        tick();
        addr_en = 1'b0;
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
        bus_addr(a);
        rd_en = 1'b1; rd_data = d;
        tick();
        rd_en = 1'b0;
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [15:0] v);
        bus_addr(a);
        wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
        v = wr_data;
    endtask

    task automatic adc_pulse();
        adc_clk = 1'b1; tick(); tick();
        adc_clk = 1'b0; tick(); tick();
    endtask

    function automatic logic [15:0] pick_addr();
        case ($urandom_range(0, 7))
            0: return A_CTRL;
            1: return A_HOLD;
            2: return A_TO;
            3: return A_DEC;
            4: return A_STAT;
            5: return 16'h4015;
            6: return 16'h0000;
            default: return 16'hFFFF;
        endcase
    endfunction

    initial begin
        logic [15:0] v;
        int t0, s0, trig_at;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_wr_data", 32'(wr_data), 32'h0000FFFF);
        check("rst_trig", 32'(trig_pulse), 32'h0);
        check("rst_stb", 32'(sample_stb), 32'h0);
        check("rst_capturing", 32'(capturing), 32'h0);
        rst_n = 1'b1;

        bus_read(A_STAT, v);   check("status_after_reset", 32'(v), 32'h0000);
        bus_read(16'h0000, v); check("unmapped_read", 32'(v), 32'hFFFF);

        // Normal mode, rising edge, DECIM=1
        bus_write(A_HOLD, 16'd0);
        bus_write(A_DEC, 16'd1);
        bus_write(A_CTRL, 16'h0005);
        repeat (3) tick();
        t0 = n_trig;
        sync_in = 1'b1;
        repeat (3) tick();
        check("normal_trig_count", n_trig - t0, 1);
        s0 = n_stb;
        repeat (6) adc_pulse();
        check("normal_stb_count", n_stb - s0, 3);
        buf_done = 1'b1; tick(); buf_done = 1'b0;
        repeat (4) tick();
        bus_read(A_STAT, v); check("status_after_done", 32'(v), 32'h010A);
        bus_read(A_STAT, v); check("status_done_cleared", 32'(v), 32'h0102);

        // Single mode, falling edge
        bus_write(A_CTRL, 16'h0003);
        repeat (2) tick();
        t0 = n_trig;
        sync_in = 1'b0;
        repeat (2) tick();
        check("single_trig_count", n_trig - t0, 1);
        buf_done = 1'b1; tick(); buf_done = 1'b0;
        repeat (3) tick();
        bus_read(A_CTRL, v); check("single_run_cleared", 32'(v), 32'h0002);
        bus_read(A_STAT, v); check("single_status", 32'(v), 32'h0208);
        t0 = n_trig;
        sync_in = 1'b1; repeat (2) tick();
        sync_in = 1'b0; repeat (2) tick();
        check("single_no_retrigger", n_trig - t0, 0);

        // Auto mode, TIMEOUT=8, comparator static
        bus_write(A_TO, 16'd8);
        bus_read(A_TO, v); check("timeout_readback", 32'(v), AUTO ? 32'd8 : 32'd0);
        bus_write(A_CTRL, 16'h0009);
        repeat (3) tick();
        t0 = n_trig; trig_at = 0;
        for (int i = 1; i <= 10; i++) begin
            adc_pulse();
            if (n_trig != t0 && trig_at == 0) trig_at = i;
        end
        check("auto_trig_at", trig_at, AUTO ? 8 : 0);
        bus_write(A_CTRL, 16'h0000);

        // Force in ARMED, then stable drop mid-capture
        bus_write(A_CTRL, 16'h0005);
        repeat (3) tick();
        t0 = n_trig;
        bus_write(A_CTRL, 16'h0015);
        tick();
        check("force_trig", n_trig - t0, 1);
        stable = 1'b0; tick(); stable = 1'b1;
        check("abort_capturing", 32'(capturing), 32'h0);
        repeat (3) tick();
        bus_read(A_STAT, v); check("abort_status", 32'(v), 32'h0202);

        // run cleared during a long holdoff
        bus_write(A_HOLD, 16'd100);
        bus_write(A_CTRL, 16'h0000);
        tick();
        bus_write(A_CTRL, 16'h0005);
        tick();
        bus_read(A_STAT, v); check("holdoff_state", 32'(v), 32'h0201);
        bus_write(A_CTRL, 16'h0004);
        tick();
        bus_read(A_STAT, v); check("run_clear_idle", 32'(v), 32'h0200);

        // Force and edge in the same cycle
        bus_write(A_HOLD, 16'd0);
        bus_write(A_CTRL, 16'h0005);
        repeat (3) tick();
        t0 = n_trig;
        bus_addr(A_CTRL);
        rd_en = 1'b1; rd_data = 16'h0015;
        tick();
        rd_en = 1'b0; sync_in = 1'b1;
        repeat (4) tick();
        check("force_edge_single_trig", n_trig - t0, 1);

        // Asynchronous reset mid-capture with a strobe showing
        adc_clk = 1'b1;
        tick();
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_stb", 32'(sample_stb), 32'h0);
        check("async_rst_capturing", 32'(capturing), 32'h0);
        check("async_rst_wr_data", 32'(wr_data), 32'h0000FFFF);
        model_reset();
        adc_clk = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b1;

        for (int seg = 0; seg < 4; seg++) begin
            stable = 1'b1; buf_done = 1'b0;
            bus_write(A_CTRL, 16'h0000);
            bus_write(A_HOLD, 16'($urandom_range(0, 4)));
            bus_write(A_TO, 16'($urandom_range(0, 6)));
            bus_write(A_DEC, 16'($urandom_range(0, 3)));
            bus_addr(A_CTRL);
            for (int c = 0; c < 600; c++) begin
                int r;
                logic [15:0] d;
                if ($urandom_range(0, 9) < 4) adc_clk = ~adc_clk;
                if ($urandom_range(0, 11) == 0) sync_in = ~sync_in;
                stable   = ($urandom_range(0, 49) != 0);
                buf_done = ($urandom_range(0, 19) == 0);
                en       = ($urandom_range(0, 9) != 0);
                addr_en = 1'b0; rd_en = 1'b0; wr_en = 1'b0;
                r = $urandom_range(0, 99);
                if (r < 5) begin
                    addr_en = 1'b1; rd_data = pick_addr();
                end else if (r < 12) begin
                    if (m_addr != A_HOLD && m_addr != A_TO && m_addr != A_DEC) begin
                        d = 16'($urandom);
                        d[0] = ($urandom_range(0, 9) != 0);
                        d[4] = ($urandom_range(0, 7) == 0);
                        rd_en = 1'b1; rd_data = d;
                    end
                end else if (r < 20) begin
                    wr_en = 1'b1;
                end
                tick();
            end
            en = 1'b1; addr_en = 1'b0; rd_en = 1'b0; wr_en = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
